aq_djpeg_mcu_seq: RTL and testbench
===================================

# aq_djpeg_mcu_seq

MCU block sequencer for the JPEG decoder back end. It latches the frame configuration (component count, subsampling, MCU grid size) and hands out 8x8 blocks one at a time over a valid/ready handshake. For each accepted block it presents the colour slot the YCbCr buffer expects and the MCU X/Y position of the current MCU. It stalls on buffer-full and signals MCU and image completion. It sits between the IDCT output stage and the YCbCr memory/convert stage, and is the single owner of the block-colour and block-position sequence.

## Interface
- No parameters.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- ProcessInit  in  1  synchronous clear to IDLE; has priority over every other input.
- Start  in  1  one-cycle pulse that latches the configuration and enters RUN; honoured only in IDLE.
- JpegComp  in  3  component count: 3 selects YCbCr; any other value selects grayscale.
- SubSamplingW  in  2  horizontal luma factor: 2 means two blocks, any other value means one.
- SubSamplingH  in  2  vertical luma factor: 2 means two blocks, any other value means one.
- McuWidth  in  12  MCUs per row; 0 is treated as 1.
- McuHeight  in  12  MCU rows; 0 is treated as 1.
- SinkFull  in  1  downstream YCbCr buffer is full.
- BlockValid  in  1  upstream offers one 8x8 block.
- BlockReady  out  1  high when state is RUN and SinkFull is 0 (combinational from state register and SinkFull).
- BlockColor  out  3  colour slot of the next block to accept: 0 to 3 are Y sub-blocks, 4 is Cb, 5 is Cr.
- McuX  out  12  column of the current MCU.
- McuY  out  12  row of the current MCU.
- McuDone  out  1  one-cycle pulse after the last block of an MCU is accepted.
- ImageDone  out  1  one-cycle pulse after the last block of the image is accepted.
- Busy  out  1  high in RUN.

## Operation
- States and transitions:
  - IDLE -> RUN on Start.
  - RUN -> DONE on the final transfer.
  - DONE -> IDLE on ProcessInit only.
  - Any state -> IDLE on ProcessInit.
- Start latches JpegComp, SubSamplingW/H, McuWidth and McuHeight. Input changes after Start are ignored until the next IDLE.
- A transfer occurs when BlockValid and BlockReady are both high in the same cycle.
- Colour sequence per MCU in YCbCr mode:
  - W=1, H=1: 0, 4, 5.
  - W=2, H=1: 0, 1, 4, 5.
  - W=1, H=2: 0, 2, 4, 5.
  - W=2, H=2: 0, 1, 2, 3, 4, 5.
- Grayscale mode: every block is one MCU and BlockColor stays 0.
- After Cr (or the single grayscale block), the MCU ends:
  - BlockColor returns to 0.
  - McuX increments. If McuX equals latched McuWidth-1, McuX wraps to 0 and McuY increments.
- Final transfer is the MCU-ending transfer with McuX == McuWidth-1 and McuY == McuHeight-1.
  - McuDone and ImageDone both pulse.
  - State goes to DONE; McuX/McuY hold their last values and BlockReady is 0.
- SinkFull rising mid-MCU freezes the sequence; no transfer and no counter change until it falls.
- Counter widths are 12 bits. Wrap arithmetic compares against McuWidth-1 computed in 12 bits, after the 0→1 substitution.

## Timing
- Reset and ProcessInit values:
  - state IDLE.
  - BlockColor 0, McuX 0, McuY 0.
  - McuDone 0, ImageDone 0, Busy 0, BlockReady 0.
- Start in cycle N: Busy=1 and BlockReady=!SinkFull from cycle N+1.
- A transfer in cycle N updates BlockColor, McuX and McuY at the N+1 edge.
- McuDone and ImageDone are registered and high during cycle N+1 only.
- Back-to-back transfers are sustained at one block per cycle; there are no bubbles at MCU boundaries.
- SinkFull affects BlockReady in the same cycle (zero latency). Upstream must not treat BlockValid alone as a transfer.
- Simultaneous events:
  - ProcessInit together with a transfer: ProcessInit wins; the transfer is discarded and no pulses are generated.
  - ProcessInit together with Start: the block ends in IDLE.
  - Start outside IDLE: ignored.
- Asynchronous rst mid-MCU returns all outputs to their reset values immediately, without waiting for a clock edge.

## Test plan
- YCbCr 4:2:0 (JpegComp=3, W=2, H=2), McuWidth=2, McuHeight=1, BlockValid held high -> BlockColor 0,1,2,3,4,5,0,1,2,3,4,5 on consecutive cycles. McuDone pulses after the 6th and 12th transfers. ImageDone pulses after the 12th transfer. BlockReady is 0 afterwards.
- Grayscale (JpegComp=1), McuWidth=3, McuHeight=2 -> 6 transfers with BlockColor always 0. (McuX,McuY) steps (0,0),(1,0),(2,0),(0,1),(1,1),(2,1). ImageDone pulses once.
- 4:2:2 (W=2, H=1) with SinkFull asserted for 4 cycles after the 2nd transfer -> BlockReady is 0 for exactly those 4 cycles, BlockColor holds 4, and the sequence resumes 4, 5, 0.
- ProcessInit asserted in the same cycle as the 3rd transfer of a 4:4:4 image -> IDLE next cycle; BlockColor, McuX and McuY are 0; no McuDone.
- McuWidth=0, McuHeight=0, 4:4:4 -> a single MCU (colours 0, 4, 5), then ImageDone.
- rst pulsed asynchronously mid-MCU, then Start -> all outputs 0 during reset, and the sequence restarts at colour 0, MCU (0,0).

Source files
------------

// File: rtl/aq_djpeg_mcu_seq.sv
// MCU block sequencer: latches the frame configuration and steps through the
// colour slots and MCU grid positions of each 8x8 block handed to the YCbCr stage.
module aq_djpeg_mcu_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        ProcessInit,
  input  logic        Start,
  input  logic [2:0]  JpegComp,
  input  logic [1:0]  SubSamplingW,
  input  logic [1:0]  SubSamplingH,
  input  logic [11:0] McuWidth,
  input  logic [11:0] McuHeight,
  input  logic        SinkFull,
  input  logic        BlockValid,
  output logic        BlockReady,
  output logic [2:0]  BlockColor,
  output logic [11:0] McuX,
  output logic [11:0] McuY,
  output logic        McuDone,
  output logic        ImageDone,
  output logic        Busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t      state;
  logic        cfgYcc;
  logic        cfgW2;
  logic        cfgH2;
  logic [11:0] lastX;
  logic [11:0] lastY;

  logic [11:0] widthEff;
  logic [11:0] heightEff;
  logic [2:0]  nextColor;
  logic        mcuEnd;
  logic        xEnd;
  logic        yEnd;
  logic        xfer;

  // A zero grid dimension is treated as a single MCU.
  assign widthEff   = (McuWidth == 12'd0) ? 12'd1 : McuWidth;
  assign heightEff  = (McuHeight == 12'd0) ? 12'd1 : McuHeight;

  assign BlockReady = (state == StRun) && !SinkFull;
  assign Busy       = (state == StRun);
  assign xfer       = BlockValid && BlockReady;
  assign xEnd       = (McuX == lastX);
  assign yEnd       = (McuY == lastY);

  // Successor colour within an MCU; mcuEnd marks the block that closes it.
  always_comb begin
    nextColor = 3'd0;
    mcuEnd    = 1'b0;
    if (!cfgYcc) begin
      mcuEnd = 1'b1;
    end else begin
      case (BlockColor)
        3'd0:    nextColor = cfgW2 ? 3'd1 : (cfgH2 ? 3'd2 : 3'd4);
        3'd1:    nextColor = cfgH2 ? 3'd2 : 3'd4;
        3'd2:    nextColor = cfgW2 ? 3'd3 : 3'd4;
        3'd3:    nextColor = 3'd4;
        3'd4:    nextColor = 3'd5;
        default: mcuEnd    = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      cfgYcc     <= 1'b0;
      cfgW2      <= 1'b0;
      cfgH2      <= 1'b0;
      lastX      <= 12'd0;
      lastY      <= 12'd0;
      BlockColor <= 3'd0;
      McuX       <= 12'd0;
      McuY       <= 12'd0;
      McuDone    <= 1'b0;
      ImageDone  <= 1'b0;
    end else begin
      McuDone   <= 1'b0;
      ImageDone <= 1'b0;
      if (ProcessInit) begin
        state      <= StIdle;
        BlockColor <= 3'd0;
        McuX       <= 12'd0;
        McuY       <= 12'd0;
      end else begin
        case (state)
          StIdle: begin
            if (Start) begin
              state      <= StRun;
              cfgYcc     <= (JpegComp == 3'd3);
              cfgW2      <= (SubSamplingW == 2'd2);
              cfgH2      <= (SubSamplingH == 2'd2);
              lastX      <= widthEff - 12'd1;
              lastY      <= heightEff - 12'd1;
              BlockColor <= 3'd0;
              McuX       <= 12'd0;
              McuY       <= 12'd0;
            end
          end
          StRun: begin
            if (xfer) begin
              if (!mcuEnd) begin
                BlockColor <= nextColor;
              end else begin
                BlockColor <= 3'd0;
                McuDone    <= 1'b1;
                if (xEnd && yEnd) begin
                  // Position holds at the last MCU once the image is complete.
                  ImageDone <= 1'b1;
                  state     <= StDone;
                end else if (xEnd) begin
                  McuX <= 12'd0;
                  McuY <= McuY + 12'd1;
                end else begin
                  McuX <= McuX + 12'd1;
                end
              end
            end
          end
          StDone: ;
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aq_djpeg_mcu_seq.sv
// Scoreboard bench for aq_djpeg_mcu_seq: directed frames push expected transfers and
// MCU pulses; a negedge monitor pops and compares them as the DUT produces them.
module tb_aq_djpeg_mcu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ProcessInit = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  JpegComp = 3'd0;
  logic [1:0]  SubSamplingW = 2'd0;
  logic [1:0]  SubSamplingH = 2'd0;
  logic [11:0] McuWidth = 12'd0;
  logic [11:0] McuHeight = 12'd0;
  logic        SinkFull = 1'b0;
  logic        BlockValid = 1'b0;
  logic        BlockReady;
  logic [2:0]  BlockColor;
  logic [11:0] McuX;
  logic [11:0] McuY;
  logic        McuDone;
  logic        ImageDone;
  logic        Busy;

  int assertCount = 0;
  int failCount = 0;

  // {colour, x, y} of each expected transfer
  logic [26:0] xferQ[$];
  // {imageDone, cumulative transfer count at the pulse}
  logic [32:0] mcuQ[$];
  int totalPushed = 0;
  int xferCount = 0;

  aq_djpeg_mcu_seq dut (
    .clk         (clk),
    .rst         (rst),
    .ProcessInit (ProcessInit),
    .Start       (Start),
    .JpegComp    (JpegComp),
    .SubSamplingW(SubSamplingW),
    .SubSamplingH(SubSamplingH),
    .McuWidth    (McuWidth),
    .McuHeight   (McuHeight),
    .SinkFull    (SinkFull),
    .BlockValid  (BlockValid),
    .BlockReady  (BlockReady),
    .BlockColor  (BlockColor),
    .McuX        (McuX),
    .McuY        (McuY),
    .McuDone     (McuDone),
    .ImageDone   (ImageDone),
    .Busy        (Busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    assertCount++;
    if (act != exp) begin
      failCount++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pushXfer(input int c, input int x, input int y);
    xferQ.push_back({c[2:0], x[11:0], y[11:0]});
    totalPushed++;
  endtask

  task automatic pushMcu(input bit img);
    mcuQ.push_back({img, totalPushed[31:0]});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startImg(input int comp, input int w, input int h, input int mw, input int mh);
    JpegComp = comp[2:0];
    SubSamplingW = w[1:0];
    SubSamplingH = h[1:0];
    McuWidth = mw[11:0];
    McuHeight = mh[11:0];
    Start = 1'b1;
    tick();
    Start = 1'b0;
    // Scramble config to show it was latched
    JpegComp = 3'd0;
    SubSamplingW = 2'd1;
    SubSamplingH = 2'd1;
    McuWidth = 12'd9;
    McuHeight = 12'd9;
    check("busy_after_start", int'(Busy), 1);
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (Busy && n < 200) begin
      tick();
      n++;
    end
    check(name, int'(Busy), 0);
    check({name, "_ready"}, int'(BlockReady), 0);
  endtask

  task automatic clearInit();
    BlockValid = 1'b0;
    ProcessInit = 1'b1;
    tick();
    ProcessInit = 1'b0;
  endtask

  // Monitor: pulses are checked before the transfer of the same cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ImageDone && !McuDone) check("image_without_mcu", 1, 0);
        if (McuDone) begin
          if (mcuQ.size() == 0) begin
            check("unexpected_mcudone", 1, 0);
          end else begin
            logic [32:0] e;
            e = mcuQ.pop_front();
            check("imagedone_flag", int'(ImageDone), int'(e[32]));
            check("mcudone_after_xfer", xferCount, int'(e[31:0]));
          end
        end
        if (BlockValid && BlockReady && !ProcessInit) begin
          xferCount++;
          if (xferQ.size() == 0) begin
            check("unexpected_xfer", 1, 0);
          end else begin
            logic [26:0] e;
            e = xferQ.pop_front();
            check("xfer_color", int'(BlockColor), int'(e[26:24]));
            check("xfer_x", int'(McuX), int'(e[23:12]));
            check("xfer_y", int'(McuY), int'(e[11:0]));
          end
        end
      end
    end
  end

  initial begin
    repeat (2) tick();
    check("rst_busy", int'(Busy), 0);
    check("rst_ready", int'(BlockReady), 0);
    rst = 1'b0;
    tick();
    check("idle_color", int'(BlockColor), 0);
    check("idle_x", int'(McuX), 0);
    check("idle_pulses", int'({McuDone, ImageDone}), 0);

    // 4:2:0, 2x1 MCUs
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < 6; c++) pushXfer(c, m, 0);
      pushMcu(m == 1);
    end
    startImg(3, 2, 2, 2, 1);
    BlockValid = 1'b1;
    waitDone("t420_done");
    check("t420_color_done", int'(BlockColor), 0);
    check("t420_x_hold", int'(McuX), 1);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("start_in_done_ignored", int'(Busy), 0);
    clearInit();

    // Grayscale 3x2
    pushXfer(0, 0, 0); pushMcu(0);
    pushXfer(0, 1, 0); pushMcu(0);
    pushXfer(0, 2, 0); pushMcu(0);
    pushXfer(0, 0, 1); pushMcu(0);
    pushXfer(0, 1, 1); pushMcu(0);
    pushXfer(0, 2, 1); pushMcu(1);
    startImg(1, 2, 2, 3, 2);
    BlockValid = 1'b1;
    waitDone("gray_done");
    check("gray_x_hold", int'(McuX), 2);
    check("gray_y_hold", int'(McuY), 1);
    clearInit();
    check("init_y", int'(McuY), 0);

    // 4:2:2 with a 4-cycle SinkFull stall after the 2nd transfer
    pushXfer(0, 0, 0); pushXfer(1, 0, 0); pushXfer(4, 0, 0); pushXfer(5, 0, 0);
    pushMcu(1);
    startImg(3, 2, 1, 1, 1);
    BlockValid = 1'b1;
    tick();
    tick();
    SinkFull = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall_ready", int'(BlockReady), 0);
      check("stall_color", int'(BlockColor), 4);
      tick();
    end
    SinkFull = 1'b0;
    #1;
    check("stall_release_ready", int'(BlockReady), 1);
    waitDone("t422_done");
    check("t422_color_wrap", int'(BlockColor), 0);
    clearInit();

    // ProcessInit on the 3rd transfer of 4:4:4
    pushXfer(0, 0, 0); pushXfer(4, 0, 0);
    startImg(3, 1, 1, 2, 1);
    BlockValid = 1'b1;
    tick();
    tick();
    ProcessInit = 1'b1;
    tick();
    ProcessInit = 1'b0;
    BlockValid = 1'b0;
    check("pinit_busy", int'(Busy), 0);
    check("pinit_color", int'(BlockColor), 0);
    check("pinit_xy", int'({McuX, McuY}), 0);
    check("pinit_mcudone", int'(McuDone), 0);
    tick();

    // Zero grid dimensions behave as 1x1
    pushXfer(0, 0, 0); pushXfer(4, 0, 0); pushXfer(5, 0, 0); pushMcu(1);
    startImg(3, 1, 1, 0, 0);
    BlockValid = 1'b1;
    waitDone("zero_done");
    clearInit();

    // Asynchronous reset mid-MCU, then a fresh frame
    pushXfer(0, 0, 0); pushXfer(4, 0, 0);
    startImg(3, 1, 1, 2, 2);
    BlockValid = 1'b1;
    tick();
    tick();
    check("pre_rst_color", int'(BlockColor), 5);
    BlockValid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", int'(Busy), 0);
    check("arst_ready", int'(BlockReady), 0);
    check("arst_color", int'(BlockColor), 0);
    check("arst_xy", int'({McuX, McuY}), 0);
    tick();
    rst = 1'b0;
    tick();
    pushXfer(0, 0, 0); pushXfer(4, 0, 0); pushXfer(5, 0, 0); pushMcu(1);
    startImg(3, 1, 1, 1, 1);
    BlockValid = 1'b1;
    waitDone("restart_done");
    BlockValid = 1'b0;
    tick();
    tick();

    check("xfer_queue_empty", xferQ.size(), 0);
    check("mcu_queue_empty", mcuQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
